// File: rtl/systolic_result_drain.sv
// Result drain for SystolicArray: counts the fill/compute latency L after Start, snapshots Accs_In while clearing the array,
// then streams ROWS*COLS words row-major; first word valid L+1 cycles after Start, words hold under Out_Ready=0.
// Optional clamp: define DRAIN_RELU_EN to output negative results as 0.
module systolic_result_drain #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int ACC_N  = 32,
  parameter int KLEN_W = 8,
  parameter int GUARD  = 2,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [KLEN_W-1:0]       K_Len,
  input  logic signed [ACC_N-1:0] Accs_In [ROWS][COLS],
  output logic                    Clear_Row [ROWS],
  output logic                    Clear_Column [COLS],
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [ACC_N-1:0] Out_Data,
  output logic [RW-1:0]           Out_Row,
  output logic [CW-1:0]           Out_Col,
  output logic                    Out_Last,
  output logic                    Busy,
  output logic                    Done
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_STREAM} state_t;

  // Counter is loaded with L-1 = K + ROWS + COLS + GUARD - 2.
  localparam logic [15:0] LAT_BASE = 16'(ROWS + COLS + GUARD - 2);

  state_t                  state;
  logic [15:0]             cnt;
  logic                    clr_q;
  logic signed [ACC_N-1:0] snap [ROWS][COLS];

  logic [15:0]             k_eff;
  logic [15:0]             cnt_load;
  logic [RW-1:0]           nxt_row;
  logic [CW-1:0]           nxt_col;
  logic                    nxt_last;

  function automatic logic signed [ACC_N-1:0] shape(input logic signed [ACC_N-1:0] v);
`ifdef DRAIN_RELU_EN
    return v[ACC_N-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    k_eff    = (K_Len == '0) ? 16'd1 : 16'(K_Len);
    cnt_load = k_eff + LAT_BASE;
  end

  // Row-major successor of the word currently presented.
  always_comb begin
    nxt_row = Out_Row;
    nxt_col = Out_Col + CW'(1);
    if (Out_Col == CW'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = Out_Row + RW'(1);
    end
    nxt_last = (nxt_row == RW'(ROWS - 1)) && (nxt_col == CW'(COLS - 1));
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) Clear_Row[r] = clr_q;
    for (int c = 0; c < COLS; c++) Clear_Column[c] = clr_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      clr_q     <= 1'b0;
      Out_Valid <= 1'b0;
      Out_Data  <= '0;
      Out_Row   <= '0;
      Out_Col   <= '0;
      Out_Last  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          snap[r][c] <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            cnt   <= cnt_load;
            Busy  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            clr_q <= 1'b1;
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_CAPTURE: begin
          // The array clears on this same edge, so word 0 comes straight from Accs_In.
          clr_q <= 1'b0;
          for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
              snap[r][c] <= Accs_In[r][c];
          Out_Valid <= 1'b1;
          Out_Data  <= shape(Accs_In[0][0]);
          Out_Row   <= '0;
          Out_Col   <= '0;
          Out_Last  <= (ROWS * COLS == 1);
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (Out_Ready) begin
            if (Out_Last) begin
              Out_Valid <= 1'b0;
              Out_Last  <= 1'b0;
              Out_Data  <= '0;
              Out_Row   <= '0;
              Out_Col   <= '0;
              Busy      <= 1'b0;
              Done      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              Out_Row  <= nxt_row;
              Out_Col  <= nxt_col;
              Out_Data <= shape(snap[nxt_row][nxt_col]);
              Out_Last <= nxt_last;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side companion of `SystolicArray`: it is the reader for the array's accumulator matrix. The block tracks the array's fill/compute latency from a `Start` pulse and snapshots `Accs_Out` once the last result has settled. In the same cycle it pulses the array's `Clear_Row`/`Clear_Column` lines, then streams the ROWS×COLS results row-major over a valid/ready interface to the downstream buffer.

## Interface
- `ROWS`, 2, array rows (M); matches `ARRAY_ROWS`
- `COLS`, 2, array columns (N); matches `ARRAY_COLUMNS`
- `ACC_N`, 32, accumulator width; matches `ARRAY_OUTPUTS_N`
- `KLEN_W`, 8, width of `K_Len`
- `GUARD`, 2, extra settle cycles added to computed latency
- `Clock`  in  1  single clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Start`  in  1  one-cycle pulse, coincident with the first skewed feed cycle (t=0)
- `K_Len`  in  KLEN_W  common dimension K, sampled with `Start`; 0 is treated as 1
- `Accs_In`  in  ACC_N signed, unpacked [ROWS][COLS]  from array `Accs_Out`
- `Clear_Row`  out  1, unpacked [ROWS]  to array; reset 0
- `Clear_Column`  out  1, unpacked [COLS]  to array; reset 0
- `Out_Valid`  out  1  result word valid; reset 0
- `Out_Ready`  in  1  downstream accepts word
- `Out_Data`  out  ACC_N signed  result word; reset 0
- `Out_Row`  out  $clog2(ROWS) (min 1)  row index of word; reset 0
- `Out_Col`  out  $clog2(COLS) (min 1)  column index of word; reset 0
- `Out_Last`  out  1  final word of the matrix; reset 0
- `Busy`  out  1  high in every state except IDLE; reset 0
- `Done`  out  1  one-cycle pulse after the last word is accepted; reset 0

## Operation
- Latency: L = (K−1) + (ROWS−1) + (COLS−1) + 2 + GUARD, where K = max(K_Len, 1). The counter is 16 bits wide.
- States: IDLE, WAIT, CAPTURE, STREAM.
- IDLE: when `Start`=1, load the counter with L−1 and go to WAIT. `K_Len` is latched on this edge.
- WAIT: decrement the counter each cycle. When the counter is 0, go to CAPTURE on the next edge.
- CAPTURE (one cycle):
  - All `Clear_Row` and `Clear_Column` bits are 1.
  - The snapshot registers load `Accs_In` on the exiting edge. The array therefore clears on the same edge the snapshot takes the final values.
  - Reset the index to 0 and go to STREAM.
- STREAM:
  - `Out_Valid`=1. `Out_Data`, `Out_Row` and `Out_Col` are registered from snapshot[idx], in row-major order (idx = r·COLS + c).
  - A word is transferred on an edge where `Out_Valid`&`Out_Ready`=1; the index then advances.
  - `Out_Last`=1 when idx = ROWS·COLS−1.
  - When the last word transfers, go to IDLE, pulse `Done` for one cycle, and clear `Out_Valid`.
- `Start` while `Busy`=1 is ignored. There is no queueing and no state change.
- `Out_Ready` outside STREAM has no effect.
- No arithmetic is performed on results, apart from the optional clamp described under Configuration.

## Timing
- With `Start` sampled at edge E0, CAPTURE is entered at edge E0+L and the first `Out_Valid` appears after edge E0+L+1.
- Example: K=2, 2×2 array, GUARD=2 gives L=7.
- With `Out_Ready` held high, one word transfers per cycle. The full matrix drains in ROWS·COLS cycles, and `Done` is asserted the cycle after the last transfer.
- Back-to-back: a `Start` in the same cycle that `Done` is high is accepted, because the block is in IDLE.
- Backpressure: while `Out_Valid`=1 and `Out_Ready`=0, `Out_Data`, `Out_Row`, `Out_Col` and `Out_Last` hold stable.
- `Out_Valid` is never withdrawn before the word transfers.
- Reset asserted at any point, including mid-WAIT or mid-STREAM:
  - The FSM goes to IDLE.
  - All outputs and snapshot registers go to 0 immediately (asynchronous).
  - No `Done` pulse is produced and no partial stream resumes after reset.

## Configuration
- `DRAIN_RELU_EN`:
  - When defined, the output stage applies ReLU: a negative snapshot value is output as 0, and a non-negative value passes unchanged.
  - When undefined, the signed snapshot value passes through unmodified.
- Timing and handshake are identical in both builds.

## Test plan
- Default 2×2 array, A=[[1,2],[3,4]], B=[[5,6],[7,8]] fed skewed with `Start` at t=0, K_Len=2, `Out_Ready`=1:
  - Clear bits pulse once, at edge E0+7.
  - Output words are 19(0,0), 22(0,1), 43(1,0), 50(1,1); `Out_Last` is set on 50; `Done` pulses once.
- Same stimulus with `Out_Ready` toggling 1,0,0,1,0,1…:
  - Each word is held stable through the stall cycles.
  - Order and values are unchanged, and exactly 4 transfers occur.
- Second `Start` issued mid-WAIT and again mid-STREAM:
  - Both are ignored; the stream is unchanged.
  - A `Start` issued in the `Done` cycle starts a new run, with CAPTURE L cycles later.
- `Reset` pulled low after the 2nd word has transferred:
  - `Out_Valid`, `Busy` and `Out_Data` go to 0 asynchronously, and no `Done` pulse occurs.
  - After release, a fresh run produces all 4 words correctly.
- A row 0 = [−1,−2], same B:
  - With `DRAIN_RELU_EN` defined, the outputs are 0, 0, 43, 50.
  - Without the macro, the outputs are −19, −22, 43, 50.
- K_Len=0:
  - It is treated as K=1, giving L=6.
  - CAPTURE occurs at E0+6 and the snapshot holds single-product results.
